// File: rtl/mc_main_ctrl_if.sv
// Control bundle between the multi-cycle main controller and the MIPS datapath.
// The controller uses the master modport; the datapath side uses the slave modport.
interface mc_main_ctrl_if #(
    parameter int ALUOP_W = 4,
    parameter int LANES   = 4
);
    logic [5:0]         opcode;
    logic [5:0]         func;
    logic               zero;
    logic               mem_ready;

    logic               mem_req;
    logic               mem_we;
    logic               iord;
    logic               pc_write;
    logic               ir_write;
    logic               regdst;
    logic               extop;
    logic               alusrc_a;
    logic               mem2reg;
    logic               regwrite;
    logic               varadd;
    logic [1:0]         alusrc_b;
    logic [1:0]         pcsrc;
    logic [ALUOP_W-1:0] aluop;
    logic [LANES-1:0]   lane_mask;
    logic [3:0]         state;
    logic               illegal;
    logic               timeout;

    modport master (
        input  opcode, func, zero, mem_ready,
        output mem_req, mem_we, iord, pc_write, ir_write, regdst, extop, alusrc_a,
               mem2reg, regwrite, varadd, alusrc_b, pcsrc, aluop, lane_mask, state,
               illegal, timeout
    );

    modport slave (
        output opcode, func, zero, mem_ready,
        input  mem_req, mem_we, iord, pc_write, ir_write, regdst, extop, alusrc_a,
               mem2reg, regwrite, varadd, alusrc_b, pcsrc, aluop, lane_mask, state,
               illegal, timeout
    );
endinterface

// File: rtl/mc_main_ctrl.sv
// Multi-cycle main controller: sequences scalar and packed MIPS instructions through
// fetch/decode/execute/memory/write-back, stalls on mem_ready and traps stickily.
module mc_main_ctrl #(
    parameter int ALUOP_W  = 4,
    parameter int LANES    = 4,
    parameter int WAIT_MAX = 15
) (
    input  logic           clk,
    input  logic           rst,
    mc_main_ctrl_if.master bus
);
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC_R   = 4'd2,
        EXEC_I   = 4'd3,
        MEM_ADDR = 4'd4,
        MEM_RD   = 4'd5,
        MEM_WR   = 4'd6,
        WB_MEM   = 4'd7,
        WB_ALU   = 4'd8,
        BRANCH   = 4'd9,
        JUMP     = 4'd10,
        TRAP     = 4'd11
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

    state_t     state_q;
    logic [7:0] wait_q;
    logic [5:0] op_q;
    logic [5:0] fn_q;
    logic       illegal_q;
    logic       timeout_q;
    logic       is_rtype;
    logic       is_packed;

    function automatic logic [ALUOP_W-1:0] func_aluop(input logic [5:0] f);
        case (f)
            6'd32:   return ALUOP_W'(2);
            6'd34:   return ALUOP_W'(3);
            6'd36:   return ALUOP_W'(0);
            6'd37:   return ALUOP_W'(1);
            6'd42:   return ALUOP_W'(4);
            default: return ALUOP_W'(5);
        endcase
    endfunction

    assign is_rtype  = (op_q == 6'd0) || (op_q == 6'd7);
    assign is_packed = (op_q == 6'd7) || (op_q == 6'd9) || (op_q == 6'd10);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= FETCH;
            wait_q    <= '0;
            op_q      <= '0;
            fn_q      <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            // NOTE: non-blocking, so the later increment in a wait state overrides this clear;
            // the counter is therefore zero on every entry to FETCH, MEM_RD and MEM_WR.
            wait_q <= '0;
            case (state_q)
                FETCH, MEM_RD, MEM_WR: begin
                    if (bus.mem_ready) begin
                        if (state_q == FETCH)       state_q <= DECODE;
                        else if (state_q == MEM_RD) state_q <= WB_MEM;
                        else                        state_q <= FETCH;
                    end else if (wait_q == WAIT_LAST) begin
                        state_q   <= TRAP;
                        timeout_q <= 1'b1;
                    end else begin
                        wait_q <= wait_q + 8'd1;
                    end
                end
                DECODE: begin
                    op_q <= bus.opcode;
                    fn_q <= bus.func;
                    case (bus.opcode)
                        6'd0, 6'd7:        state_q <= EXEC_R;
                        6'd8, 6'd9:        state_q <= EXEC_I;
                        6'd35, 6'd43:      state_q <= MEM_ADDR;
                        6'd4, 6'd5, 6'd10: state_q <= BRANCH;
                        6'd2:              state_q <= JUMP;
                        6'd6:              state_q <= FETCH;
                        default: begin
                            state_q   <= TRAP;
                            illegal_q <= 1'b1;
                        end
                    endcase
                end
                EXEC_R, EXEC_I: state_q <= WB_ALU;
                MEM_ADDR:       state_q <= (op_q == 6'd35) ? MEM_RD : MEM_WR;
                TRAP:           state_q <= TRAP;
                default:        state_q <= FETCH;
            endcase
        end
    end

    // Decode is combinational so FETCH and BRANCH can follow mem_ready/zero within the cycle,
    // and so every output drops the instant rst rises.
    always_comb begin
        // NOTE: every output is defaulted first; a path that skips one would infer a latch.
        bus.mem_req   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.iord      = 1'b0;
        bus.pc_write  = 1'b0;
        bus.ir_write  = 1'b0;
        bus.regdst    = 1'b0;
        bus.extop     = 1'b0;
        bus.alusrc_a  = 1'b0;
        bus.mem2reg   = 1'b0;
        bus.regwrite  = 1'b0;
        bus.varadd    = 1'b0;
        bus.alusrc_b  = 2'd0;
        bus.pcsrc     = 2'd0;
        bus.aluop     = '0;
        bus.lane_mask = '0;
        if (!rst) begin
            bus.varadd    = is_packed;
            bus.lane_mask = is_packed ? {LANES{1'b1}} : LANES'(1);
            case (state_q)
                FETCH: begin
                    bus.mem_req  = 1'b1;
                    bus.alusrc_b = 2'd1;
                    bus.aluop    = ALUOP_W'(2);
                    bus.pc_write = bus.mem_ready;
                    bus.ir_write = bus.mem_ready;
                end
                DECODE: begin
                    bus.alusrc_b = 2'd3;
                    bus.aluop    = ALUOP_W'(2);
                    bus.extop    = 1'b1;
                end
                EXEC_R: begin
                    bus.alusrc_a = 1'b1;
                    bus.aluop    = func_aluop(fn_q);
                end
                EXEC_I, MEM_ADDR: begin
                    bus.alusrc_a = 1'b1;
                    bus.alusrc_b = 2'd2;
                    bus.extop    = 1'b1;
                    bus.aluop    = ALUOP_W'(2);
                end
                WB_ALU: begin
                    bus.regwrite = 1'b1;
                    bus.mem2reg  = 1'b1;
                    bus.regdst   = is_rtype;
                    bus.alusrc_a = 1'b1;
                    bus.alusrc_b = is_rtype ? 2'd0 : 2'd2;
                    bus.aluop    = is_rtype ? func_aluop(fn_q) : ALUOP_W'(2);
                end
                MEM_RD: begin
                    bus.mem_req = 1'b1;
                    bus.iord    = 1'b1;
                end
                MEM_WR: begin
                    bus.mem_req = 1'b1;
                    bus.mem_we  = 1'b1;
                    bus.iord    = 1'b1;
                end
                WB_MEM: bus.regwrite = 1'b1;
                BRANCH: begin
                    bus.alusrc_a = 1'b1;
                    bus.pcsrc    = 2'd1;
                    bus.aluop    = (op_q == 6'd4) ? ALUOP_W'(3) : ALUOP_W'(4);
                    bus.pc_write = (op_q == 6'd4) ? bus.zero : ~bus.zero;
                end
                JUMP: begin
                    bus.pcsrc    = 2'd2;
                    bus.pc_write = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.state   = state_q;
    assign bus.illegal = illegal_q;
    assign bus.timeout = timeout_q;
endmodule

// File: doc/mc_main_ctrl.md
# mc_main_ctrl

Multi-cycle successor to the single-cycle main decoder. It sequences each MIPS instruction, scalar or packed, through fetch, decode, execute, memory and write-back states, and stalls on a memory ready handshake. It drives the datapath muxes, ALU and register file of the multi-cycle MIPS core, and raises a sticky trap on an illegal opcode or a memory timeout.

## Interface
- ALUOP_W, 4: width of aluop.
- LANES, 4: packed-lane count; width of lane_mask.
- WAIT_MAX, 15: maximum cycles to wait for mem_ready before trapping (1..255).
- clk  in  1  rising-edge clock.
- rst  in  1  reset; asynchronous, active-high.
- opcode  in  6  instruction opcode from IR.
- func  in  6  R-type function field from IR.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req, mem_we, iord  out  1  memory request, write enable, address select (0 = PC, 1 = ALUOut).
- pc_write, ir_write  out  1  PC and IR load enables.
- regdst, extop, alusrc_a, mem2reg, regwrite, varadd  out  1  datapath controls, same meaning as in the single-cycle core.
- alusrc_b  out  2  ALU B select: 0 = reg, 1 = const 4, 2 = imm, 3 = imm<<2.
- pcsrc  out  2  PC source: 0 = ALU, 1 = ALUOut (branch), 2 = jump target.
- aluop  out  ALUOP_W  ALU operation: 0 AND, 1 OR, 2 ADD, 3 SUB, 4 SLT, 5 default.
- lane_mask  out  LANES  active lanes: all ones for packed ops, 1 for scalar ops.
- state  out  4  current state encoding, for debug.
- illegal, timeout  out  1  sticky trap causes.

## Operation
- States: FETCH 0, DECODE 1, EXEC_R 2, EXEC_I 3, MEM_ADDR 4, MEM_RD 5, MEM_WR 6, WB_MEM 7, WB_ALU 8, BRANCH 9, JUMP 10, TRAP 11.
- FETCH:
  - Drives mem_req=1, iord=0, alusrc_a=0, alusrc_b=1, aluop=2, pcsrc=0.
  - pc_write=ir_write=mem_ready (Mealy).
  - Moves to DECODE when mem_ready=1.
- DECODE:
  - Latches opcode and func into internal registers. All later states use only the latched copies.
  - Drives alusrc_b=3, aluop=2, extop=1.
- Dispatch from DECODE:
  - Opcode 0 and 7 go to EXEC_R.
  - Opcode 8 and 9 go to EXEC_I.
  - Opcode 35 and 43 go to MEM_ADDR.
  - Opcode 4, 5 and 10 go to BRANCH.
  - Opcode 2 goes to JUMP.
  - Opcode 6 is a no-op and returns to FETCH.
  - Any other opcode goes to TRAP and sets illegal=1.
- EXEC_R:
  - Drives alusrc_a=1, alusrc_b=0.
  - aluop from func: 32→2, 34→3, 36→0, 37→1, 42→4, else 5.
  - Next state is WB_ALU.
- EXEC_I: alusrc_a=1, alusrc_b=2, extop=1, aluop=2. Next state is WB_ALU.
- WB_ALU:
  - regwrite=1, mem2reg=1.
  - regdst=1 for opcode 0 and 7, otherwise 0.
  - Holds the aluop/alusrc of the preceding EXEC state. Next state is FETCH.
- MEM_ADDR: alusrc_a=1, alusrc_b=2, extop=1, aluop=2. Goes to MEM_RD for opcode 35 and MEM_WR for opcode 43.
- MEM_RD: mem_req=1, iord=1. Goes to WB_MEM when mem_ready=1.
- MEM_WR: mem_req=1, mem_we=1, iord=1. Goes to FETCH when mem_ready=1.
- WB_MEM: regwrite=1, mem2reg=0, regdst=0. Next state is FETCH.
- BRANCH:
  - alusrc_a=1, alusrc_b=0, pcsrc=1.
  - aluop=3 for opcode 4, aluop=4 for opcode 5 and 10.
  - pc_write=zero for opcode 4 and ~zero for opcode 5 and 10.
  - Next state is FETCH.
- JUMP: pcsrc=2, pc_write=1. Next state is FETCH.
- TRAP:
  - Absorbing; left only by reset.
  - All enables are 0. illegal and timeout hold their values.
- varadd=1 and lane_mask all ones when the latched opcode is 7, 9 or 10. Otherwise varadd=0 and lane_mask=1.
- Any output not listed for a state is 0.
- Wait counter:
  - Clears on entry to FETCH, MEM_RD or MEM_WR.
  - Increments each cycle the block waits with mem_ready=0.
  - If the counter reaches WAIT_MAX with mem_ready still 0, the next state is TRAP and timeout=1.
  - mem_ready=1 in the same cycle as the limit wins: the access completes with no trap.

## Timing
- While rst=1:
  - state=FETCH; wait counter, latched opcode/func, illegal and timeout are 0.
  - Every output is forced to 0.
- First mem_req is in the first cycle after rst falls.
- Reset mid-instruction abandons it immediately (asynchronous). No write enable may be seen while rst=1.
- Minimum cycles with zero-wait memory:
  - R, addi, ptype, paddi: 4.
  - lw: 5.
  - sw: 4.
  - branch: 3.
  - j: 3.
  - opcode 6: 2.
- Each memory wait cycle adds 1 cycle.
- Changes on the opcode/func inputs after DECODE have no effect.

## Test plan
- Reset, then R-type add (opcode 0, func 32), mem_ready tied 1:
  - States 0→1→2→8→0.
  - In WB_ALU: regwrite=1, regdst=1, aluop=2.
  - pc_write=ir_write=1 only in FETCH.
- lw (35) with mem_ready low for 3 cycles in MEM_RD:
  - Holds MEM_RD with mem_req=1, iord=1 for 4 cycles.
  - Then WB_MEM with regwrite=1, mem2reg=0.
  - Total 8 cycles.
- beq (4) with zero=1, then zero=0:
  - BRANCH pc_write=1 then 0; pcsrc=1, aluop=3.
  - pbne (10) with zero=0 gives pc_write=1, varadd=1, lane_mask=4'b1111.
- Opcode 63: DECODE→TRAP, illegal=1, all enables 0 for 20 cycles. rst pulse clears everything.
- Timeout (WAIT_MAX=15):
  - mem_ready held 0 in FETCH: TRAP after 15 wait cycles, timeout=1.
  - mem_ready=1 exactly on the 15th cycle: normal DECODE, no trap.
- Async reset asserted mid-EXEC between clock edges: outputs drop to 0 immediately; state=FETCH after rst falls.
